module_bcd_to_binary: RTL and testbench

- Sequential BCD-to-binary converter: turns NUM_DIGITS packed BCD digits into an unsigned binary value using the iterative reverse double-dabble algorithm (shift right, then subtract 3 from any digit >= 8).
- Sits between BCD-entry sources (keypad/display digit registers) and the arithmetic/PMOD datapath.
- Uses a start/done handshake and flags invalid BCD input.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/module_sub3.sv | 12 +
 rtl/module_bcd_to_binary.sv | 139 +++++++++++++
 tb/tb_module_bcd_to_binary.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter slice.
package bcd_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  // Width of one packed BCD digit
  localparam int BCD_DIGIT_W = 4;

  // A BCD digit is legal only in the range 0..9
  function automatic logic is_valid_bcd_digit(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/module_sub3.sv
// Per-digit correction step of reverse double-dabble: digits that reach 8 or
// more after the right shift get 3 removed so they stay valid BCD.
module module_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;

endmodule

// File: rtl/module_bcd_to_binary.sv
// Iterative BCD-to-binary converter: one right shift plus per-digit
// correction per clock, 4*NUM_DIGITS shifts per conversion, start/done
// handshake and an error flag for digits above 9.
module module_bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            START,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] BCD_IN,
  output logic [BIN_W-1:0]                BIN_OUT,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERROR
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  // The binary half is as wide as the digit half so that every bit shifted
  // out of the digits is kept; the low BIN_W bits are the result.
  localparam int SR_W  = 2 * BCD_W;
  localparam int CNT_W = $clog2(BCD_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);
  localparam logic [63:0] MAX_DEC = 64'(10 ** NUM_DIGITS) - 64'd1;

  // The largest decimal input must be representable on BIN_OUT
  if ((64'd1 << BIN_W) <= MAX_DEC) begin : g_bin_w_check
    $error("BIN_W too small to hold 10**NUM_DIGITS-1");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [SR_W-1:0]  r_shift;
  logic [SR_W-1:0]  w_shifted;
  logic [SR_W-1:0]  w_corrected;
  logic [CNT_W-1:0] r_count;
  logic [BIN_W-1:0] r_bin;
  logic             r_error;
  logic             w_all_valid;
  logic             w_last_shift;

  // Flag the input as convertible only when every digit is 0..9
  always_comb begin
    w_all_valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_valid_bcd_digit(BCD_IN[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        w_all_valid = 1'b0;
      end
    end
  end

  assign w_shifted    = r_shift >> 1;
  assign w_last_shift = (r_count == LAST_SHIFT);
  assign w_corrected[BCD_W-1:0] = w_shifted[BCD_W-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_sub3
    module_sub3 u_sub3 (
      .i_digit (w_shifted[BCD_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_corrected[BCD_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and the BUSY/DONE status outputs
  always_comb begin
    w_next_state = r_state;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_next_state = w_all_valid ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (w_last_shift) begin
          w_next_state = FINISH;
        end
      end
      FINISH: begin
        BUSY         = 1'b1;
        DONE         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, shift/correct while converting, capture result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
      r_bin   <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            if (w_all_valid) begin
              r_shift <= {BCD_IN, {BCD_W{1'b0}}};
              r_count <= '0;
              r_error <= 1'b0;
            end else begin
              r_bin   <= '0;
              r_error <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_shift <= w_corrected;
          r_count <= r_count + CNT_W'(1);
          if (w_last_shift) begin
            r_bin <= BIN_W'(w_corrected[BCD_W-1:0]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BIN_OUT = r_bin;
  assign ERROR   = r_error;

endmodule

// File: tb/tb_module_bcd_to_binary.sv
// Self-checking bench for module_bcd_to_binary: a driver pushes expected
// results into a scoreboard queue and a monitor pops them on every DONE.
module tb_module_bcd_to_binary;

  logic        clk = 1'b0;
  logic        rst;
  logic        START;
  logic [11:0] BCD_IN;
  logic [9:0]  BIN_OUT;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  typedef struct {
    logic [9:0] bin;
    logic       err;
    int         issue;
    int         lat;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  int   lastDone = 0;
  int   prevDone = 0;

  module_bcd_to_binary #(
    .NUM_DIGITS (3),
    .BIN_W      (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .START   (START),
    .BCD_IN  (BCD_IN),
    .BIN_OUT (BIN_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERROR   (ERROR)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp accepts and DONE pulses
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges the whole run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && DONE) begin
      prevDone = lastDone;
      lastDone = cycleCount;
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected DONE: got DONE with BIN_OUT %0d, expected no DONE", BIN_OUT);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("BIN_OUT", 32'(BIN_OUT), 32'(e.bin));
        checkOutput("ERROR", 32'(ERROR), 32'(e.err));
        checkOutput("latency", 32'(cycleCount + 1 - e.issue), 32'(e.lat));
      end
    end
  end

  // Called at a negedge with the DUT idle; pulses START for one edge
  task automatic applyStimulus(input logic [11:0] bcd, input logic [9:0] expBin,
                               input logic expErr, input int expLat);
    exp_t e;
    START  = 1'b1;
    BCD_IN = bcd;
    e.bin   = expBin;
    e.err   = expErr;
    e.issue = cycleCount + 1;
    e.lat   = expLat;
    sbQueue.push_back(e);
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
  endtask

  // Waits (bounded) for DONE, counting busy cycles, and returns in the first idle cycle
  task automatic waitForDone(output int busyCnt);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    busyCnt = 0;
    while (!seen && n < 40) begin
      if (BUSY) busyCnt++;
      if (DONE) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no DONE in %0d cycles, expected DONE", n);
    end
    @(negedge clk);
  endtask

  // Main directed sequence
  initial begin
    int busyCnt;
    logic [11:0] bcd;
    rst    = 1'b1;
    START  = 1'b0;
    BCD_IN = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset BIN_OUT", 32'(BIN_OUT), 0);
    checkOutput("reset BUSY", 32'(BUSY), 0);
    checkOutput("reset DONE", 32'(DONE), 0);
    checkOutput("reset ERROR", 32'(ERROR), 0);
    rst = 1'b0;
    @(negedge clk);

    // 255 with latency and busy-length checks
    applyStimulus(12'h255, 10'd255, 1'b0, 13);
    waitForDone(busyCnt);
    checkOutput("busy cycles 255", 32'(busyCnt), 13);
    checkOutput("idle BUSY", 32'(BUSY), 0);
    checkOutput("held BIN_OUT", 32'(BIN_OUT), 255);

    // Back-to-back 999 then 000
    applyStimulus(12'h999, 10'd999, 1'b0, 13);
    waitForDone(busyCnt);
    applyStimulus(12'h000, 10'd0, 1'b0, 13);
    waitForDone(busyCnt);
    checkOutput("done spacing", 32'(lastDone - prevDone), 14);

    // Invalid digit then a valid conversion
    applyStimulus(12'h1A3, 10'd0, 1'b1, 1);
    waitForDone(busyCnt);
    checkOutput("busy cycles invalid", 32'(busyCnt), 1);
    checkOutput("held ERROR", 32'(ERROR), 1);
    applyStimulus(12'h103, 10'd103, 1'b0, 13);
    waitForDone(busyCnt);

    // START while busy is ignored and BCD_IN changes have no effect
    applyStimulus(12'h128, 10'd128, 1'b0, 13);
    repeat (4) @(negedge clk);
    START  = 1'b1;
    BCD_IN = 12'h777;
    @(negedge clk);
    START = 1'b0;
    waitForDone(busyCnt);
    repeat (16) @(negedge clk);

    // Reset mid-conversion aborts without a DONE
    applyStimulus(12'h500, 10'd500, 1'b0, 13);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort BUSY", 32'(BUSY), 0);
    checkOutput("abort DONE", 32'(DONE), 0);
    checkOutput("abort BIN_OUT", 32'(BIN_OUT), 0);
    checkOutput("abort ERROR", 32'(ERROR), 0);
    rst = 1'b0;
    sbQueue.delete();
    repeat (16) @(negedge clk);
    applyStimulus(12'h042, 10'd42, 1'b0, 13);
    waitForDone(busyCnt);

    // Full sweep 000..999, back-to-back
    for (int v = 0; v < 1000; v++) begin
      bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      applyStimulus(bcd, 10'(v), 1'b0, 13);
      waitForDone(busyCnt);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
